// File: rtl/mem_arb_pkg.sv
// Shared types and default memory geometry for the memory arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr,
// wrapping; next_ptr is the slot after the winner when adv is set.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    input  logic               adv,
    output logic [NUM_REQ-1:0] win,
    output logic [PW-1:0]      win_idx,
    output logic               any_valid,
    output logic [PW-1:0]      next_ptr
);

    always_comb begin
        win_idx   = '0;
        any_valid = 1'b0;
        // Scan downward so the last hit is the lowest index at/after ptr.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                win_idx   = PW'(i);
                any_valid = 1'b1;
            end
        end
        if (!any_valid) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_idx   = PW'(i);
                    any_valid = 1'b1;
                end
            end
        end

        for (int i = 0; i < NUM_REQ; i++)
            win[i] = any_valid && (win_idx == PW'(i));

        next_ptr = ptr;
        if (adv && any_valid)
            next_ptr = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of a registered-read synchronous memory; one
// transaction in flight, all outputs registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MEM_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_in,
    input  logic [DATA_WIDTH-1:0]         mem_data_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                  state;
    logic [PW-1:0]           ptr, next_ptr, win_idx;
    logic [NUM_REQ-1:0]      win, owner;
    logic                    any_valid, we_q;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .req       (req),
        .ptr       (ptr),
        .adv       (state == IDLE),
        .win       (win),
        .win_idx   (win_idx),
        .any_valid (any_valid),
        .next_ptr  (next_ptr)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            we_q        <= 1'b0;
            gnt         <= '0;
            done        <= '0;
            rdata       <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt         <= win;
                        owner       <= win;
                        we_q        <= sel_we;
                        mem_addr    <= sel_addr;
                        mem_data_in <= sel_wdata;
                        mem_write   <= sel_we;
                        mem_read    <= !sel_we;
                        ptr         <= next_ptr;
                        state       <= ACCESS;
                    end
                end
                // Memory samples the strobes on the edge leaving this state.
                ACCESS: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    if (we_q) begin
                        done  <= owner;
                        state <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata <= mem_data_out;
                    done  <= owner;
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_rw_excl: assert property (@(posedge clk) disable iff (!rst_) !(mem_read && mem_write));
    a_gnt_oh:  assert property (@(posedge clk) disable iff (!rst_) $onehot0(gnt));
    a_done_oh: assert property (@(posedge clk) disable iff (!rst_) $onehot0(done));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-level
// reference: RR order, fixed grant/done timing and a shadow memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_ = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rdata, mem_data_in, mem_data_out;
    logic            mem_read, mem_write;
    logic [AW-1:0]   mem_addr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] tb_mem  [32];
    logic [DW-1:0] ref_mem [32];

    int            edge_cnt = 0;
    logic [N-1:0]    req_s = '0, we_s = '0;
    logic [N*AW-1:0] addr_s = '0;
    logic [N*DW-1:0] wdata_s = '0;

    int obs_gnt = 0, obs_done = 0;
    int dut_log[$];

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .rdata        (rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 29 + 7) ^ 8'h5A;
    endfunction

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Synchronous 32x8 memory with registered read.
    initial begin
        for (int a = 0; a < 32; a++) tb_mem[a] = init_val(a);
        tb_mem[3] = 8'h11;
        tb_mem[7] = 8'h22;
        forever begin
            @(posedge clk);
            if (mem_write) tb_mem[mem_addr] <= mem_data_in;
            if (mem_read)  mem_data_out <= tb_mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        req_s    <= req;
        we_s     <= req_we;
        addr_s   <= req_addr;
        wdata_s  <= req_wdata;
    end

    // Reference: a grant is due whenever the arbiter is free and someone asks;
    // writes occupy 3 cycles (done after 1), reads 4 (done after 2).
    initial begin
        int rr_ptr, free_edge, done_edge, w, d_who;
        logic g_we, d_we;
        logic [AW-1:0] g_addr, d_addr;
        logic [DW-1:0] g_data, d_data;
        logic [N-1:0] exp_gnt, exp_done;
        rr_ptr = 0; free_edge = 0; done_edge = -1; d_who = 0;
        g_we = 1'b0; d_we = 1'b0; g_addr = '0; d_addr = '0; g_data = '0; d_data = '0;
        for (int a = 0; a < 32; a++) ref_mem[a] = init_val(a);
        ref_mem[3] = 8'h11;
        ref_mem[7] = 8'h22;
        forever begin
            @(negedge clk);
            if (!rst_) begin
                rr_ptr = 0; free_edge = 0; done_edge = -1;
            end else begin
                exp_gnt = '0;
                if (edge_cnt >= free_edge && req_s != '0) begin
                    w = pick(rr_ptr, req_s);
                    exp_gnt[w] = 1'b1;
                    rr_ptr = (w + 1) % N;
                    g_we   = we_s[w];
                    g_addr = addr_s[w*AW +: AW];
                    g_data = wdata_s[w*DW +: DW];
                    free_edge = edge_cnt + (g_we ? 3 : 4);
                    done_edge = edge_cnt + (g_we ? 1 : 2);
                    d_who = w; d_we = g_we; d_addr = g_addr; d_data = g_data;
                end
                chk("gnt", 32'(gnt), 32'(exp_gnt));
                if (exp_gnt != '0) begin
                    chk("mem_write", 32'(mem_write), 32'(g_we));
                    chk("mem_read", 32'(mem_read), 32'(!g_we));
                    chk("mem_addr", 32'(mem_addr), 32'(g_addr));
                    if (g_we) chk("mem_data_in", 32'(mem_data_in), 32'(g_data));
                end else begin
                    chk("strobes_idle", 32'({mem_read, mem_write}), 32'd0);
                end
                exp_done = '0;
                if (edge_cnt == done_edge) begin
                    exp_done[d_who] = 1'b1;
                    if (d_we) ref_mem[d_addr] = d_data;
                    else      chk("rdata", 32'(rdata), 32'(ref_mem[d_addr]));
                end
                chk("done", 32'(done), 32'(exp_done));
                chk("rw_excl", 32'(mem_read & mem_write), 32'd0);
                for (int i = 0; i < N; i++) if (gnt[i]) dut_log.push_back(i);
                obs_gnt  += $countones(gnt);
                obs_done += $countones(done);
            end
        end
    end

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_gnt(input int i, input bit drop, output int cyc);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!gnt[i] && cyc < 40);
        chk("gnt_wait", 32'(gnt[i]), 32'd1);
        if (drop) req[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!done[i] && cyc < 20);
        chk("done_wait", 32'(done[i]), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_data_in), 32'd0);
    endtask

    initial begin
        int c, dn, g0, d0;
        rst_ = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk); #1 rst_ = 1'b1;
        @(posedge clk); #1;

        // Single write then read through requester 0.
        set_req(0, 1'b1, 5'd5, 8'hA5);
        wait_gnt(0, 1'b1, c);  chk("gnt_latency", c, 1);
        wait_done(0, c);       chk("wr_latency", c, 1);
        set_req(0, 1'b0, 5'd5, 8'h00);
        wait_gnt(0, 1'b1, c);
        wait_done(0, c);       chk("rd_latency", c, 2);
        chk("rd_a5", 32'(rdata), 32'h0A5);

        // Contention: both readers held, grants must alternate.
        dut_log.delete();
        set_req(0, 1'b0, 5'd3, 8'h00);
        set_req(1, 1'b0, 5'd7, 8'h00);
        repeat (24) @(posedge clk);
        #1 req = '0;
        repeat (8) @(posedge clk);
        #1;
        chk("contention_cnt", 32'(dut_log.size() >= 5), 32'd1);
        for (int k = 1; k < dut_log.size(); k++)
            chk("alternate", dut_log[k], dut_log[k-1] ^ 1);

        // Back-to-back writes from requester 1, then read them all back.
        for (int a = 0; a < 32; a++) begin
            set_req(1, 1'b1, 5'(a), 8'(a) ^ 8'hFF);
            wait_gnt(1, a == 31, c);
            if (a > 0) chk("wr_spacing", c, 3);
        end
        wait_done(1, c);
        for (int a = 0; a < 32; a++) begin
            set_req(1, 1'b0, 5'(a), 8'h00);
            wait_gnt(1, 1'b1, c);
            wait_done(1, c);
            chk("rd_b2b", 32'(rdata), 32'(8'(a) ^ 8'hFF));
        end

        // Fields change right after grant; the latched value must be written.
        set_req(0, 1'b1, 5'd2, 8'h3C);
        wait_gnt(0, 1'b1, c);
        req_wdata[0 +: DW] = 8'hC3;
        wait_done(0, c);
        @(posedge clk); #1;
        chk("field_hold_mem", 32'(tb_mem[2]), 32'h03C);
        set_req(0, 1'b0, 5'd2, 8'h00);
        wait_gnt(0, 1'b1, c);
        wait_done(0, c);
        chk("field_hold_rd", 32'(rdata), 32'h03C);

        // Reset in the middle of a read access.
        set_req(0, 1'b0, 5'd9, 8'h00);
        wait_gnt(0, 1'b1, c);
        chk("pre_rst_read", 32'(mem_read), 32'd1);
        #1 rst_ = 1'b0;
        #1 chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        #1 rst_ = 1'b1;
        dn = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done != '0) dn++;
        end
        chk("abort_no_done", dn, 0);

        // Random traffic.
        g0 = obs_gnt;
        d0 = obs_done;
        repeat (2000) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req[i] && gnt[i])
                    req[i] = 1'b0;
                else if (req[i] && $urandom_range(0, 15) == 0)
                    req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
            end
        end
        @(posedge clk); #1 req = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("gnt_done_count", obs_done - d0, obs_gnt - g0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
